osd_stm_event_buffer: RTL

Buffers and timestamps software trace events between the per-core STM adapter and the STM packetizer. It sits downstream of the adapter, which produces trace_valid/trace_id/trace_value from the core trace port, and upstream of the packetizer that consumes events under valid/ready.
- Decouples single-cycle, non-stallable trace events from a back-pressured packetizer.
- Counts events dropped while the buffer is full and reports them as an in-band overflow record. ID 0x0000 is reserved for this record; the adapter never emits ID 0.

---
 rtl/osd_stm_event_buffer_pkg.sv | 14 +
 rtl/osd_fifo_sync.sv | 51 +++++
 rtl/osd_stm_event_buffer.sv | 84 ++++++++
 3 files changed

// File: rtl/osd_stm_event_buffer_pkg.sv
// opensocdebug: shared STM trace event record and the reserved overflow ID.
package opensocdebug;

    localparam logic [15:0] STM_ID_OVERFLOW = 16'h0000;
    localparam int STM_VALWIDTH = 32;
    localparam int STM_TSWIDTH = 32;

    typedef struct packed {
        logic [15:0]             id;
        logic [STM_VALWIDTH-1:0] value;
        logic [STM_TSWIDTH-1:0]  timestamp;
    } osd_stm_event;

endpackage

// File: rtl/osd_fifo_sync.sv
// osd_fifo_sync: synchronous FIFO; head entry is read combinationally, pushes while full are dropped.
module osd_fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // full is taken from the registered count, so a same-cycle pop never makes room
    assign full    = count_q == (AW+1)'(DEPTH);
    assign empty   = count_q == '0;
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(do_push);
            rd_ptr_q <= rd_ptr_q + AW'(do_pop);
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/osd_stm_event_buffer.sv
// osd_stm_event_buffer: timestamps non-stallable trace events into a FIFO and
// reports events dropped while full as an in-band overflow record (ID 0).
module osd_stm_event_buffer
    import opensocdebug::*;
#(
    parameter int VALWIDTH = 32,
    parameter int DEPTH    = 8,
    parameter int TSWIDTH  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                trace_valid,
    input  logic [15:0]         trace_id,
    input  logic [VALWIDTH-1:0] trace_value,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [15:0]         out_id,
    output logic [VALWIDTH-1:0] out_value,
    output logic [TSWIDTH-1:0]  out_timestamp,
    output logic                lost_pending
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [15:0]         id;
        logic [VALWIDTH-1:0] value;
        logic [TSWIDTH-1:0]  timestamp;
    } event_t;

    event_t                wr_evt, fifo_rd, rd_evt;
    logic [TSWIDTH-1:0]    ts_q, ts_d;
    logic [VALWIDTH-1:0]   lost_cnt_q, lost_cnt_d;
    logic [AW:0]           count;
    logic                  full, empty, capture, ovf_wr, evt_wr;

    osd_fifo_sync #(
        .WIDTH ($bits(event_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (ovf_wr || evt_wr),
        .wr_data (wr_evt),
        .pop     (out_valid && out_ready),
        .rd_data (fifo_rd),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // a pending overflow record always wins the write slot, so it precedes later events
    always_comb begin
        capture    = trace_valid && enable;
        ovf_wr     = (lost_cnt_q != '0) && !full;
        evt_wr     = capture && !full && (lost_cnt_q == '0);
        wr_evt     = ovf_wr ? event_t'{STM_ID_OVERFLOW, lost_cnt_q, ts_q}
                            : event_t'{trace_id, trace_value, ts_q};
        lost_cnt_d = ovf_wr ? VALWIDTH'(capture)
                   : (capture && full && !(&lost_cnt_q)) ? lost_cnt_q + 1'b1
                   : lost_cnt_q;
        ts_d       = ts_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q       <= '0;
            lost_cnt_q <= '0;
        end else begin
            ts_q       <= ts_d;
            lost_cnt_q <= lost_cnt_d;
        end
    end

    // storage is not reset, so blank the head while empty
    assign rd_evt        = empty ? '0 : fifo_rd;
    assign out_valid     = count != '0;
    assign out_id        = rd_evt.id;
    assign out_value     = rd_evt.value;
    assign out_timestamp = rd_evt.timestamp;
    assign lost_pending  = lost_cnt_q != '0;

endmodule
